// File: rtl/laca_4_bit.sv
// rtl/laca_4_bit.sv - 4-bit carry-lookahead adder slice with registered sum, carry, group P/G and overflow
// All carries are flat functions of g, p and c0 so the slice can sit under a higher-level lookahead unit.
module laca_4_bit #(
   parameter int IN_REG = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] n1,
   input  logic [3:0] n2,
   input  logic       c0,
   output logic [3:0] sum,
   output logic       carry,
   output logic       pg,
   output logic       gg,
   output logic       ovf
);

   logic [3:0] w_a;
   logic [3:0] w_b;
   logic       w_cin;

   generate
      if (IN_REG != 0) begin : g_in_reg
         logic [3:0] r_n1;
         logic [3:0] r_n2;
         logic       r_c0;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_n1 <= 4'd0;
               r_n2 <= 4'd0;
               r_c0 <= 1'b0;
            end else begin
               r_n1 <= n1;
               r_n2 <= n2;
               r_c0 <= c0;
            end
         end

         assign w_a   = r_n1;
         assign w_b   = r_n2;
         assign w_cin = r_c0;
      end else begin : g_no_in_reg
         assign w_a   = n1;
         assign w_b   = n2;
         assign w_cin = c0;
      end
   endgenerate

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic       w_c1;
   logic       w_c2;
   logic       w_c3;
   logic       w_c4;
   logic       w_pg;
   logic       w_gg;
   logic [3:0] w_sum;
   logic       w_ovf;

   assign w_g = w_a & w_b;
   assign w_p = w_a ^ w_b;

   // Each carry is a two-level sum of products; none feeds another.
   assign w_c1 = w_g[0]
               | (w_p[0] & w_cin);
   assign w_c2 = w_g[1]
               | (w_p[1] & w_g[0])
               | (w_p[1] & w_p[0] & w_cin);
   assign w_c3 = w_g[2]
               | (w_p[2] & w_g[1])
               | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_cin);

   assign w_pg = &w_p;
   assign w_gg = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

   assign w_c4  = w_gg | (w_pg & w_cin);
   assign w_sum = w_p ^ {w_c3, w_c2, w_c1, w_cin};
   assign w_ovf = w_c4 ^ w_c3;

   logic [3:0] r_sum;
   logic       r_carry;
   logic       r_pg;
   logic       r_gg;
   logic       r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum   <= 4'd0;
         r_carry <= 1'b0;
         r_pg    <= 1'b0;
         r_gg    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_sum   <= w_sum;
         r_carry <= w_c4;
         r_pg    <= w_pg;
         r_gg    <= w_gg;
         r_ovf   <= w_ovf;
      end
   end

   assign sum   = r_sum;
   assign carry = r_carry;
   assign pg    = r_pg;
   assign gg    = r_gg;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_laca_4_bit.sv
// tb/tb_laca_4_bit.sv - checks both latency variants of laca_4_bit against an arithmetic reference
module tb_laca_4_bit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] n1;
   logic [3:0] n2;
   logic       c0;

   logic [3:0] sum0, sum1;
   logic       carry0, carry1, pg0, pg1, gg0, gg1, ovf0, ovf1;

   int checks   = 0;
   int failures = 0;

   logic [8:0] hist[$];

   always #5 clk = ~clk;

   laca_4_bit #(.IN_REG(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .n1(n1), .n2(n2), .c0(c0),
      .sum(sum0), .carry(carry0), .pg(pg0), .gg(gg0), .ovf(ovf0)
   );

   laca_4_bit #(.IN_REG(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .n1(n1), .n2(n2), .c0(c0),
      .sum(sum1), .carry(carry1), .pg(pg1), .gg(gg1), .ovf(ovf1)
   );

   // Packed as {carry, sum[3:0], pg, gg, ovf}.
   function automatic logic [7:0] model(input logic [8:0] v);
      int a, b, c, total, sa, sb, ssum;
      logic [3:0] s;
      logic co, p, g, o;
      a = int'(v[8:5]);
      b = int'(v[4:1]);
      c = int'(v[0]);
      total = a + b + c;
      s  = 4'(total % 16);
      co = (total >= 16);
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      ssum = sa + sb + c;
      o = (ssum > 7) || (ssum < -8);
      p = ((a ^ b) == 15);
      g = (a + b) >= 16;
      return {co, s, p, g, o};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b expected=%b (carry,sum,pg,gg,ovf) at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] out0();
      return {carry0, sum0, pg0, gg0, ovf0};
   endfunction

   function automatic logic [7:0] out1();
      return {carry1, sum1, pg1, gg1, ovf1};
   endfunction

   task automatic cycle(input logic [3:0] a, input logic [3:0] b, input logic c);
      logic [7:0] exp1;
      n1 = a;
      n2 = b;
      c0 = c;
      hist.push_back({a, b, c});
      @(posedge clk);
      @(negedge clk);
      check("lat1", out0(), model(hist[hist.size()-1]));
      exp1 = (hist.size() >= 2) ? model(hist[hist.size()-2]) : 8'h00;
      check("lat2", out1(), exp1);
   endtask

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic       c;
      logic [7:0] exp;
   } dir_t;

   dir_t dirs[5];

   initial begin
      dirs[0] = '{a: 4'd3,  b: 4'd5,  c: 1'b0, exp: 8'b0_1000_0_0_1};
      dirs[1] = '{a: 4'd15, b: 4'd1,  c: 1'b0, exp: 8'b1_0000_0_1_0};
      dirs[2] = '{a: 4'd15, b: 4'd15, c: 1'b1, exp: 8'b1_1111_0_1_0};
      dirs[3] = '{a: 4'hA,  b: 4'h5,  c: 1'b0, exp: 8'b0_1111_1_0_0};
      dirs[4] = '{a: 4'hA,  b: 4'h5,  c: 1'b1, exp: 8'b1_0000_1_0_0};

      rst_n = 1'b0;
      n1 = 4'hF;
      n2 = 4'hF;
      c0 = 1'b1;

      repeat (3) begin
         @(posedge clk);
         #1;
         check("rst_edge0", out0(), 8'h00);
         check("rst_edge1", out1(), 8'h00);
         @(negedge clk);
         check("rst_mid0", out0(), 8'h00);
         check("rst_mid1", out1(), 8'h00);
      end
      #2 rst_n = 1'b1;

      foreach (dirs[i]) begin
         cycle(dirs[i].a, dirs[i].b, dirs[i].c);
         check("directed", out0(), dirs[i].exp);
      end

      for (int i = 0; i < 512; i++) begin
         logic [8:0] v;
         v = 9'(i);
         cycle(v[8:5], v[4:1], v[0]);
      end

      for (int i = 0; i < 200; i++) begin
         logic [8:0] v;
         v = 9'($urandom);
         cycle(v[8:5], v[4:1], v[0]);
      end

      cycle(4'd7, 4'd9, 1'b1);
      cycle(4'd6, 4'd6, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("midrst0", out0(), 8'h00);
      check("midrst1", out1(), 8'h00);
      #1 rst_n = 1'b1;
      hist.delete();
      cycle(4'd2, 4'd3, 1'b1);
      cycle(4'd9, 4'd4, 1'b0);
      check("post_rst_first", out1(), model({4'd2, 4'd3, 1'b1}));
      cycle(4'd1, 4'd1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/laca_4_bit.md
Name: laca_4_bit

Overview:
- 4-bit carry-lookahead adder: adds operands n1, n2 and carry-in c0.
- Produces a 4-bit sum and a carry-out, plus group propagate/generate and signed overflow.
- Explicit lookahead carry equations; no ripple chain.
- Results registered on the clock; usable standalone or as a slice of a wider hierarchical CLA.

Parameters:
- IN_REG, default 0: 1 = register n1/n2/c0 before the CLA core (latency 2); 0 = core fed directly from ports (latency 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- n1  input  4  operand A, unsigned (two's complement for ovf)
- n2  input  4  operand B
- c0  input  1  carry-in
- sum  output  4  registered (n1 + n2 + c0) mod 16
- carry  output  1  registered carry-out, bit 4 of n1 + n2 + c0
- pg  output  1  registered group propagate, p3&p2&p1&p0
- gg  output  1  registered group generate, g3 | p3g2 | p3p2g1 | p3p2p1g0
- ovf  output  1  registered signed overflow, c4 ^ c3

Behaviour:
- Reset: rst_n low asynchronously clears sum, carry, pg, gg, ovf and any input registers to 0, independent of clk. Outputs hold 0 until the first rising edge after rst_n deasserts.
- Per bit i = 0..3: gi = n1[i] & n2[i]; pi = n1[i] ^ n2[i].
- Carries are flat lookahead terms of g, p and c0 only. No carry may depend on another computed carry.
  - c1 = g0 | p0c0
  - c2 = g1 | p1g0 | p1p0c0
  - c3 = g2 | p2g1 | p2p1g0 | p2p1p0c0
  - c4 = gg | (pg & c0)
- Sum and status:
  - sum[i] = pi ^ ci
  - carry = c4
  - ovf = c4 ^ c3
- Latency:
  - IN_REG=0: outputs reflect inputs sampled at rising edge k, visible after edge k.
  - IN_REG=1: inputs captured at edge k; results visible after edge k+1.
- One new operand set is accepted every cycle. No handshake, no stall; fully pipelined.
- Inputs changing between edges have no effect on outputs until the next edge. No glitch propagation to outputs.
- Wrap-around: sum is modulo 16; overflow out of 4 bits is reported only via carry.
  - Example: 15 + 15 + 1 gives sum=15, carry=1.
- pg and gg are independent of c0.
- pg=1 implies gg=0, since p and g of a bit are mutually exclusive.
- Reset asserted mid-operation: all pipeline stages are cleared. In-flight results are discarded, not delivered after reset release.
- Reset released coincident with a rising edge: that edge is ignored. The first capture occurs on the following edge.
- X-free: every output is a defined function of registered state after reset.

Test Plan:
- Reset check: rst_n=0 while n1=4'hF, n2=4'hF, c0=1 are driven and clk toggles.
  - Required: sum=0, carry=0, pg=0, gg=0, ovf=0 for the whole reset interval, including between clock edges.
- Basic add: n1=3, n2=5, c0=0.
  - Required after latency: sum=8, carry=0, ovf=1 (signed 3+5 overflows 4 bits), pg=0, gg=0.
- Carry wrap: n1=15, n2=1, c0=0 gives sum=0, carry=1, pg=0, gg=1.
  - Then n1=15, n2=15, c0=1 gives sum=15, carry=1.
- Propagate chain: n1=4'b1010, n2=4'b0101.
  - c0=0 gives sum=15, carry=0, pg=1, gg=0.
  - c0=1 gives sum=0, carry=1, pg=1, gg=0.
- Exhaustive back-to-back: all 512 (n1, n2, c0) combinations applied one per cycle, for IN_REG=0 and IN_REG=1.
  - Each output matches the reference model {carry,sum} = n1+n2+c0 exactly LATENCY cycles later.
  - ovf, pg and gg also match the formulas above for every combination.
- Mid-stream reset: pulse rst_n low for half a cycle while non-zero results are in flight.
  - Outputs go to 0 immediately.
  - No stale result appears after release.
  - The first post-reset result corresponds to the first operands sampled after release.
